// File: rtl/hex_operand_entry.sv
// Purpose: push-button front end that builds two hex operands (a, b) for the adder datapath.
// Latency: a button sampled high at clock edge k updates a/b/state at edge k+SYNC_STAGES.
// Backpressure: none; every key edge is consumed in its cycle, and a one-cycle valid marks a finished pair.
//
// Ports:
//   hz100  - system clock, rising edge
//   reset  - asynchronous, active-high; clears operands, FSM, synchronizers
//   pb     - raw buttons: [15:0] hex digits, [16] ENTER, [17] CLEAR, [18] ALLCLR, [19] BKSP
//   a, b   - operand registers driven straight into the adder
//   valid  - one-cycle pulse after operand B is committed
//   state  - 0 = ENTER_A, 1 = ENTER_B, 2 = DONE
module hex_operand_entry #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [19:0]      pb,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int KEY_ENTER  = 16;
    localparam int KEY_CLEAR  = 17;
    localparam int KEY_ALLCLR = 18;
    localparam int KEY_BKSP   = 19;

    logic [SYNC_STAGES-1:0][19:0] sync_q;
    logic [19:0]                  prev_q;
    logic [19:0]                  rise;

    logic                         digit_hit;
    logic [3:0]                   digit_val;

    logic [WIDTH-1:0]             cur;
    logic [WIDTH-1:0]             a_nxt;
    logic [WIDTH-1:0]             b_nxt;
    logic [1:0]                   state_nxt;
    logic                         valid_nxt;

    // Button synchronizer chain plus one history stage for edge detection.
    // Clearing the history on reset makes a key held through reset release
    // look like a single fresh press.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pb;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Ascending scan so the highest-index digit edge overrides lower ones.
    always_comb begin
        digit_hit = |rise[15:0];
        digit_val = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (rise[i]) begin
                digit_val = 4'(i);
            end
        end
    end

    // Only one event acts per cycle: ALLCLR > CLEAR > ENTER > BKSP > digit.
    always_comb begin
        a_nxt     = a;
        b_nxt     = b;
        state_nxt = state;
        valid_nxt = 1'b0;
        cur       = (state == ST_ENTER_B) ? b : a;

        if (rise[KEY_ALLCLR]) begin
            a_nxt     = '0;
            b_nxt     = '0;
            state_nxt = ST_ENTER_A;
        end else if (rise[KEY_CLEAR]) begin
            if (state == ST_ENTER_A) a_nxt = '0;
            if (state == ST_ENTER_B) b_nxt = '0;
        end else if (rise[KEY_ENTER]) begin
            if (state == ST_ENTER_A) begin
                state_nxt = ST_ENTER_B;
            end else if (state == ST_ENTER_B) begin
                state_nxt = ST_DONE;
                valid_nxt = 1'b1;
            end
        end else if (rise[KEY_BKSP]) begin
            if (state == ST_ENTER_A) a_nxt = {4'h0, cur[WIDTH-1:4]};
            if (state == ST_ENTER_B) b_nxt = {4'h0, cur[WIDTH-1:4]};
        end else if (digit_hit) begin
            if (state == ST_ENTER_A) begin
                a_nxt = {cur[WIDTH-5:0], digit_val};
            end else if (state == ST_ENTER_B) begin
                b_nxt = {cur[WIDTH-5:0], digit_val};
            end else begin
                // A digit after a finished pair starts a new operand A.
                a_nxt     = {{(WIDTH-4){1'b0}}, digit_val};
                b_nxt     = '0;
                state_nxt = ST_ENTER_A;
            end
        end

        // Unreachable encoding: recover to a clean entry state.
        if (state == 2'd3) begin
            state_nxt = ST_ENTER_A;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            a     <= '0;
            b     <= '0;
            state <= ST_ENTER_A;
            valid <= 1'b0;
        end else begin
            a     <= a_nxt;
            b     <= b_nxt;
            state <= state_nxt;
            valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_hex_operand_entry.sv
// Purpose: directed self-checking bench for hex_operand_entry.
// Latency: keys are pulsed for one clock, then the bench waits past the synchronizer delay.
// Backpressure: none; valid pulses are counted by a free-running monitor.
module tb_hex_operand_entry;

    localparam int WIDTH = 16;

    localparam logic [19:0] K_ENTER  = 20'h1_0000;
    localparam logic [19:0] K_CLEAR  = 20'h2_0000;
    localparam logic [19:0] K_ALLCLR = 20'h4_0000;
    localparam logic [19:0] K_BKSP   = 20'h8_0000;

    logic             hz100;
    logic             reset;
    logic [19:0]      pb;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid;
    logic [1:0]       state;

    int n_checks;
    int n_pass;
    int valid_cnt;
    int valid_run;
    int valid_max_run;
    int base_cnt;

    hex_operand_entry #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .hz100(hz100),
        .reset(reset),
        .pb   (pb),
        .a    (a),
        .b    (b),
        .valid(valid),
        .state(state)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    // Count valid pulses and the longest run of consecutive high cycles.
    initial begin
        valid_cnt     = 0;
        valid_run     = 0;
        valid_max_run = 0;
        forever begin
            @(negedge hz100);
            if (valid === 1'b1) begin
                valid_cnt++;
                valid_run++;
                if (valid_run > valid_max_run) valid_max_run = valid_run;
            end else begin
                valid_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One-cycle key pulse, then enough idle cycles for sync + edge detect.
    task automatic press(input logic [19:0] mask);
        @(negedge hz100);
        pb = mask;
        @(negedge hz100);
        pb = '0;
        repeat (3) @(negedge hz100);
    endtask

    task automatic digit(input int d);
        logic [19:0] m;
        m = 20'd1 << d;
        press(m);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        base_cnt = 0;
        pb       = '0;
        reset    = 1'b1;
        repeat (3) @(negedge hz100);

        check("reset_a",     32'(a),     32'h0);
        check("reset_b",     32'(b),     32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_state", 32'(state), 32'h0);

        @(negedge hz100);
        reset = 1'b0;
        repeat (2) @(negedge hz100);

        // Full pair entry.
        base_cnt = valid_cnt;
        repeat (4) digit(9);
        check("t1_a_partial", 32'(a), 32'h9999);
        press(K_ENTER);
        check("t1_state_b", 32'(state), 32'h1);
        repeat (4) digit(9);
        press(K_ENTER);
        check("t1_a",     32'(a),     32'h9999);
        check("t1_b",     32'(b),     32'h9999);
        check("t1_state", 32'(state), 32'h2);
        check("t1_valid_count", 32'(valid_cnt - base_cnt), 32'h1);

        // Digit shifting and backspace.
        press(K_ALLCLR);
        check("t2_allclr_a",     32'(a),     32'h0);
        check("t2_allclr_b",     32'(b),     32'h0);
        check("t2_allclr_state", 32'(state), 32'h0);
        for (int d = 1; d <= 5; d++) digit(d);
        check("t2_shift", 32'(a), 32'h2345);
        repeat (2) press(K_BKSP);
        check("t2_bksp2", 32'(a), 32'h0023);
        repeat (3) press(K_BKSP);
        check("t2_bksp_sat", 32'(a), 32'h0000);

        // Simultaneous edges.
        press((20'd1 << 3) | (20'd1 << 10));
        check("t3_multi_digit", 32'(a), 32'h000A);
        press(K_ENTER);
        digit(1);
        check("t3_b_entry", 32'(b), 32'h0001);
        press(K_ENTER | K_ALLCLR);
        check("t3_allclr_a",     32'(a),     32'h0);
        check("t3_allclr_b",     32'(b),     32'h0);
        check("t3_allclr_state", 32'(state), 32'h0);
        digit(4);
        press(K_CLEAR | (20'd1 << 5));
        check("t3_clear_over_digit", 32'(a), 32'h0);
        check("t3_clear_state",      32'(state), 32'h0);

        // Held key acts once; DONE behaviour.
        @(negedge hz100);
        pb = 20'd1 << 7;
        repeat (50) @(negedge hz100);
        pb = '0;
        repeat (3) @(negedge hz100);
        check("t4_hold", 32'(a), 32'h0007);
        press(K_ENTER);
        digit(2);
        press(K_ENTER);
        check("t4_done_state", 32'(state), 32'h2);
        press(K_BKSP);
        press(K_CLEAR);
        press(K_ENTER);
        check("t4_done_hold_a",     32'(a),     32'h0007);
        check("t4_done_hold_b",     32'(b),     32'h0002);
        check("t4_done_hold_state", 32'(state), 32'h2);
        digit(4);
        check("t4_restart_state", 32'(state), 32'h0);
        check("t4_restart_a",     32'(a),     32'h0004);
        check("t4_restart_b",     32'(b),     32'h0);

        // Asynchronous reset mid-entry, key held across release.
        press(K_ALLCLR);
        digit(10);
        digit(11);
        digit(0);
        press(K_ENTER);
        digit(1);
        check("t5_pre_a",     32'(a),     32'h0AB0);
        check("t5_pre_b",     32'(b),     32'h0001);
        check("t5_pre_state", 32'(state), 32'h1);
        @(negedge hz100);
        #1 reset = 1'b1;
        #1;
        check("t5_async_a",     32'(a),     32'h0);
        check("t5_async_b",     32'(b),     32'h0);
        check("t5_async_state", 32'(state), 32'h0);
        check("t5_async_valid", 32'(valid), 32'h0);
        pb = 20'd1 << 6;
        repeat (3) @(negedge hz100);
        reset = 1'b0;
        repeat (20) @(negedge hz100);
        pb = '0;
        repeat (4) @(negedge hz100);
        check("t5_held_across_reset", 32'(a),     32'h0006);
        check("t5_held_state",        32'(state), 32'h0);

        // Back-to-back ENTER pulses one idle cycle apart.
        base_cnt = valid_cnt;
        @(negedge hz100);
        pb = K_ENTER;
        @(negedge hz100);
        pb = '0;
        @(negedge hz100);
        pb = K_ENTER;
        @(negedge hz100);
        pb = '0;
        repeat (5) @(negedge hz100);
        check("t6_state",       32'(state), 32'h2);
        check("t6_valid_count", 32'(valid_cnt - base_cnt), 32'h1);
        check("t6_a_kept",      32'(a),     32'h0006);
        check("valid_max_run",  32'(valid_max_run), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
